// File: rtl/mux_sincrono_rr.sv
// Pipelined N-channel registered multiplexer with direct select and round-robin scan.
// Two register stages: S1 captures the selection, stage 2 drives the outputs.
module mux_sincrono_rr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  input  logic [N_CH-1:0]          i_ch_en,
  input  logic [SEL_W-1:0]         i_selector,
  input  logic                     i_mode,
  input  logic                     i_valid,
  input  logic                     i_hold,
  output logic [DATA_W-1:0]        o_q,
  output logic [SEL_W-1:0]         o_channel,
  output logic                     o_valid,
  output logic                     o_err
);

  localparam int unsigned IDX_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] RR_RST = SEL_W'(N_CH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  ch;
    logic              valid;
    logic              err;
  } stage_t;

  stage_t            s1_q, s1_d;
  stage_t            s2_q, s2_d;
  logic [SEL_W-1:0]  rr_last_q, rr_last_d;

  logic [DATA_W-1:0] dir_word;
  logic              dir_ok;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx;
  logic [DATA_W-1:0] rr_word;
  logic [IDX_W-1:0]  cand;

  // Direct-mode word and round-robin grant search starting just after rr_last
  always_comb begin
    dir_word = '0;
    dir_ok   = (IDX_W'(i_selector) < IDX_W'(N_CH));
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (i_selector == SEL_W'(k)) dir_word = i_data[k*DATA_W +: DATA_W];
    end

    rr_found = 1'b0;
    rr_idx   = '0;
    rr_word  = '0;
    cand     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = IDX_W'(rr_last_q) + IDX_W'(i + 1);
      if (cand >= IDX_W'(N_CH)) cand = cand - IDX_W'(N_CH);
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!rr_found && (cand == IDX_W'(k)) && i_ch_en[k]) begin
          rr_found = 1'b1;
          rr_idx   = SEL_W'(k);
          rr_word  = i_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next-state for both stages and the scan pointer; hold freezes everything
  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    rr_last_d = rr_last_q;
    if (!i_hold) begin
      s2_d = s1_q;
      if (!i_valid) begin
        s1_d.valid = 1'b0;
        s1_d.err   = 1'b0;
      end else if (!i_mode) begin
        if (dir_ok) begin
          s1_d.data  = dir_word;
          s1_d.ch    = i_selector;
          s1_d.valid = 1'b1;
          s1_d.err   = 1'b0;
        end else begin
          s1_d.data  = '0;
          s1_d.valid = 1'b0;
          s1_d.err   = 1'b1;
        end
      end else begin
        s1_d.err = 1'b0;
        if (rr_found) begin
          s1_d.data  = rr_word;
          s1_d.ch    = rr_idx;
          s1_d.valid = 1'b1;
          rr_last_d  = rr_idx;
        end else begin
          s1_d.valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      rr_last_q <= RR_RST;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign o_q       = s2_q.data;
  assign o_channel = s2_q.ch;
  assign o_valid   = s2_q.valid;
  assign o_err     = s2_q.err;

endmodule

// File: tb/tb_mux_sincrono_rr.sv
// Self-checking bench for mux_sincrono_rr: vector table, corner-case sequences,
// and randomized traffic against a behavioural model.
module tb_mux_sincrono_rr;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [3:0]  en;
  logic [1:0]  sel;
  logic        mode, valid, hold;
  logic [7:0]  q;
  logic [1:0]  ch;
  logic        ov, oe;

  logic [23:0] data3;
  logic [2:0]  en3;
  logic [1:0]  sel3;
  logic        mode3, valid3, hold3;
  logic [7:0]  q3;
  logic [1:0]  ch3;
  logic        ov3, oe3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_sincrono_rr #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_ch_en(en), .i_selector(sel),
    .i_mode(mode), .i_valid(valid), .i_hold(hold),
    .o_q(q), .o_channel(ch), .o_valid(ov), .o_err(oe)
  );

  mux_sincrono_rr #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data3), .i_ch_en(en3), .i_selector(sel3),
    .i_mode(mode3), .i_valid(valid3), .i_hold(hold3),
    .o_q(q3), .o_channel(ch3), .o_valid(ov3), .o_err(oe3)
  );

  // Behavioural model of the 4-channel instance: a sample slot and an output slot
  int       m_rr;
  bit [7:0] m_s1_d, m_out_d;
  int       m_s1_ch, m_out_ch;
  bit       m_s1_v, m_s1_e, m_out_v, m_out_e;

  task automatic model_edge();
    bit [7:0] words [N];
    int       g;
    for (int k = 0; k < N; k++) words[k] = data[k*8 +: 8];
    if (rst) begin
      m_s1_d = 0; m_s1_ch = 0; m_s1_v = 0; m_s1_e = 0;
      m_out_d = 0; m_out_ch = 0; m_out_v = 0; m_out_e = 0;
      m_rr = N - 1;
    end else if (!hold) begin
      m_out_d = m_s1_d; m_out_ch = m_s1_ch; m_out_v = m_s1_v; m_out_e = m_s1_e;
      if (!valid) begin
        m_s1_v = 0; m_s1_e = 0;
      end else if (!mode) begin
        if (int'(sel) < N) begin
          m_s1_d = words[sel]; m_s1_ch = int'(sel); m_s1_v = 1; m_s1_e = 0;
        end else begin
          m_s1_d = 0; m_s1_v = 0; m_s1_e = 1;
        end
      end else begin
        g = -1;
        for (int off = 1; off <= N; off++) begin
          if (g < 0 && en[(m_rr + off) % N]) g = (m_rr + off) % N;
        end
        m_s1_e = 0;
        if (g >= 0) begin
          m_s1_d = words[g]; m_s1_ch = g; m_s1_v = 1; m_rr = g;
        end else begin
          m_s1_v = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eq, input logic [1:0] ech,
                           input logic ev, input logic ee);
    check({name, ".q"}, 32'(q), 32'(eq));
    check({name, ".ch"}, 32'(ch), 32'(ech));
    check({name, ".valid"}, 32'(ov), 32'(ev));
    check({name, ".err"}, 32'(oe), 32'(ee));
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] en;
    logic       valid;
    logic [7:0] eq;
    logic [1:0] ech;
    logic       ev;
    logic       ee;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // direct sweep, then round-robin with mask 1011, empty mask, and resume
    tbl[0]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 8'hB1, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 4'b0000, 1'b1, 8'hC2, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 8'hD3, 2'd3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 8'hD3, 2'd3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hD3, 2'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hB1, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hD3, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hB1, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 8'hD3, 2'd3, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hD3, 2'd3, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 4'b1011, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b0};

    data3 = 24'h332211; en3 = 3'b111; sel3 = 2'd0; mode3 = 1'b0; valid3 = 1'b0; hold3 = 1'b0;

    // Reset with random inputs, hold included
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      data = $urandom; en = 4'($urandom); sel = 2'($urandom); mode = 1'($urandom);
      valid = 1'($urandom); hold = 1'($urandom);
      step();
      check_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    end
    rst = 1'b0; hold = 1'b0; data = 32'hD3C2B1A0;
    mode = 1'b1; en = 4'b1111; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    check_out("first_rr", 8'hA0, 2'd0, 1'b1, 1'b0);

    // Table-driven vectors
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; en = tbl[i].en; valid = tbl[i].valid;
      step();
      check_out($sformatf("tbl%0d", i), tbl[i].eq, tbl[i].ech, tbl[i].ev, tbl[i].ee);
    end

    // Hold for 3 cycles mid-scan, then mid-stream reset
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; en = 4'b1111; valid = 1'b1;
    step();
    step();
    check_out("pre_hold", 8'hA0, 2'd0, 1'b1, 1'b0);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      valid = 1'($urandom); en = 4'($urandom);
      step();
      check_out("hold", 8'hA0, 2'd0, 1'b1, 1'b0);
    end
    hold = 1'b0; valid = 1'b1; en = 4'b1111;
    step();
    check_out("resume1", 8'hB1, 2'd1, 1'b1, 1'b0);
    step();
    check_out("resume2", 8'hC2, 2'd2, 1'b1, 1'b0);
    rst = 1'b1; hold = 1'b1;
    step();
    check_out("mid_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; hold = 1'b0;
    step();
    check_out("post_rst0", 8'h00, 2'd0, 1'b0, 1'b0);
    step();
    check_out("post_rst1", 8'hA0, 2'd0, 1'b1, 1'b0);

    // Mode switch: direct accesses leave the scan pointer alone
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b0; sel = 2'd2; valid = 1'b1;
    step();
    step();
    check_out("direct2", 8'hC2, 2'd2, 1'b1, 1'b0);
    mode = 1'b1; en = 4'b1111;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      check(c == 4 ? "mswitch_wrap" : "mswitch_ch", 32'(ch), 32'(c % 4));
    end

    // Out-of-range selector on the 3-channel instance
    valid3 = 1'b1; sel3 = 2'd3;
    step();
    check("oor_e0", 32'(oe3), 32'd0);
    valid3 = 1'b0; sel3 = 2'd0;
    step();
    check("oor_err", 32'(oe3), 32'd1);
    check("oor_valid", 32'(ov3), 32'd0);
    step();
    check("oor_err_clear", 32'(oe3), 32'd0);
    valid3 = 1'b1; sel3 = 2'd2;
    step();
    valid3 = 1'b0;
    step();
    check("n3_sel2_q", 32'(q3), 32'h33);
    check("n3_sel2_ch", 32'(ch3), 32'd2);
    check("n3_sel2_valid", 32'(ov3), 32'd1);
    check("n3_sel2_err", 32'(oe3), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 31) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      valid = ($urandom_range(0, 3) != 0);
      mode  = 1'($urandom);
      en    = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      sel   = 2'($urandom);
      data  = $urandom;
      step();
      check("rnd.q", 32'(q), 32'(m_out_d));
      check("rnd.ch", 32'(ch), 32'(m_out_ch));
      check("rnd.valid", 32'(ov), 32'(m_out_v));
      check("rnd.err", 32'(oe), 32'(m_out_e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
